// File: rtl/ifetch24_pkg.sv
// Fetch-stage types: the RUN/HALTED state and the HALT decode helper.
package ifetch24_pkg;
    import isa24_pkg::*;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    function automatic logic is_halt(input logic [IW-1:0] w);
        return opcode(w) == OP_HALT;
    endfunction

endpackage

// File: rtl/isa24_pkg.sv
// ISA-wide constants for the 24-bit core, shared between fetch and decode.
package isa24_pkg;

    localparam int IW = 24;
    localparam int OP_MSB = 23;
    localparam int OP_LSB = 20;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h3;
    localparam logic [3:0] OP_LI    = 4'h4;
    localparam logic [3:0] OP_LOAD  = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_BEQ   = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;

    function automatic logic [3:0] opcode(input logic [IW-1:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/ifetch24_if.sv
// Fetch-stage bus: instruction-memory port, IR handshake to decode, redirect from execute.
// IR handshake: a word moves when ir_valid & ir_ready are both high on a rising edge;
// ir_valid never waits on ir_ready, and a transfer coinciding with redirect is void.
interface ifetch24_if #(parameter int PC_W = 16);
    import isa24_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [IW-1:0]   imem_rdata;
    logic [IW-1:0]   ir;
    logic [PC_W-1:0] ir_pc;
    logic            ir_valid;
    logic            ir_ready;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            halted;

    modport master (
        output imem_req, imem_addr, ir, ir_pc, ir_valid, halted,
        input  imem_rdata, ir_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_pc, ir_valid, halted,
        output imem_rdata, ir_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/ifetch24_ifq2.sv
// Two-entry FIFO whose head is a register, so ir/ir_pc come straight from flops.
module ifq2 #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] e0_q, e1_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else if (flush_i) begin
            cnt_q <= 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_q <= din_i;
                    else               e1_q <= din_i;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; only the order of the entries moves.
                    if (cnt_q == 2'd2) begin
                        e0_q <= e1_q;
                        e1_q <= din_i;
                    end else begin
                        e0_q <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_o = cnt_q;
    assign head_o  = e0_q;

endmodule

// File: rtl/ifetch24.sv
// Instruction fetch: PC, one-deep request pipeline into a synchronous imem, 2-entry IR queue.
module ifetch24
    import isa24_pkg::*;
    import ifetch24_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    ifetch24_if.master   bus,
    output fetch_state_e state_o
);

    localparam int QW = IW + PC_W;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] tag_q, tag_d;
    logic            inflight_q, inflight_d;
    logic            squash_q, squash_d;

    logic [1:0]      count;
    logic [QW-1:0]   head;
    logic            run, pop, halt_xfer, issue, push, flush;
    logic [2:0]      occ;

    ifq2 #(.W(QW)) u_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   ({bus.imem_rdata, tag_q}),
        .pop_i   (pop),
        .flush_i (flush),
        .count_o (count),
        .head_o  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            squash_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            squash_q   <= squash_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        squash_d   = 1'b0;
        run        = (state_q == ST_RUN);
        pop        = run & (count != 2'd0) & bus.ir_ready & ~bus.redirect;
        halt_xfer  = pop & is_halt(head[QW-1:PC_W]);
        // Credit counts queued plus in-flight words, minus the word leaving this cycle.
        occ        = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.redirect) begin
                    pc_d     = bus.redirect_pc;
                    squash_d = inflight_q;
                end else if (halt_xfer) begin
                    state_d = ST_HALTED;
                end else if (rst_n && (occ < 3'd2)) begin
                    issue      = 1'b1;
                    pc_d       = pc_q + PC_W'(1);
                    tag_d      = pc_q;
                    inflight_d = 1'b1;
                end
            end
            default: ;
        endcase
        push  = inflight_q & ~squash_q;
        flush = ~run | bus.redirect | halt_xfer;
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;
    assign bus.ir        = head[QW-1:PC_W];
    assign bus.ir_pc     = head[PC_W-1:0];
    assign bus.ir_valid  = run & (count != 2'd0);
    assign bus.halted    = (state_q == ST_HALTED);
    assign state_o       = state_q;

endmodule
